phase_gen_multi: RTL

- Parametrised multi-channel phase/strobe generator driven from clk_100M.
- One shared frame counter cycles 0..period-1. Each channel output is high inside its own programmable [rise, fall) window, and windows may wrap past the end of the frame.
- The frame freezes while `run` is low, so downstream stages stall while a multi-cycle unit is busy.
- Period and windows are runtime-programmable through shadow registers that commit only at a frame boundary, so a frame never glitches.

---
 rtl/phase_gen_multi.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/phase_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : phase_gen_multi
//  Purpose  : Multi-channel phase/strobe generator. A shared frame counter
//             runs 0..period-1 while run is high; each channel is high inside
//             its own [rise, fall) window, which may wrap past the frame end.
//             Period and windows are staged in shadow registers and committed
//             only on the wrap edge so a frame never glitches.
//  Revision : 1.0 - initial release
// ============================================================================
module phase_gen_multi #(
  parameter int                          NUM_CH     = 4,
  parameter int                          CNT_W      = 6,
  parameter int                          DEF_PERIOD = 21,
  parameter logic [NUM_CH*CNT_W-1:0]     DEF_RISE   = {6'd16, 6'd9, 6'd1, 6'd7},
  parameter logic [NUM_CH*CNT_W-1:0]     DEF_FALL   = {6'd2, 6'd14, 6'd2, 6'd14}
) (
  input  logic                 clk_100M,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [2*CNT_W-1:0]   cfg_wdata,
  output logic [NUM_CH-1:0]    phase_out,
  output logic                 frame_start,
  output logic                 cfg_pending,
  output logic [CNT_W-1:0]     cnt_out
);

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO       = '0;
  localparam logic [CNT_W-1:0] C_MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_DEF_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [4:0]       C_MAX_ADDR   = 5'(NUM_CH);

  // Frame counter and registered outputs
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]       phase_q, phase_d;
  logic                    fs_q, fs_d;
  logic                    pend_q, pend_d;

  // Active configuration (drives the windows) and its shadow copy
  logic [CNT_W-1:0]        per_act_q, per_act_d;
  logic [CNT_W-1:0]        per_sh_q, per_sh_d;
  logic [NUM_CH*CNT_W-1:0] rise_act_q, rise_act_d;
  logic [NUM_CH*CNT_W-1:0] fall_act_q, fall_act_d;
  logic [NUM_CH*CNT_W-1:0] rise_sh_q, rise_sh_d;
  logic [NUM_CH*CNT_W-1:0] fall_sh_q, fall_sh_d;

  logic [NUM_CH-1:0]       win_hit;
  logic                    wrap;
  logic                    wr_valid;
  logic [CNT_W-1:0]        wr_period;

  // Per-channel window decode against the current count; raw compares, so a
  // fall point at or beyond the period simply keeps the channel high to wrap.
  always_comb begin
    win_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise_act_q[i*CNT_W +: CNT_W] < fall_act_q[i*CNT_W +: CNT_W]) begin
        win_hit[i] = (cnt_q >= rise_act_q[i*CNT_W +: CNT_W]) &&
                     (cnt_q <  fall_act_q[i*CNT_W +: CNT_W]);
      end else if (rise_act_q[i*CNT_W +: CNT_W] > fall_act_q[i*CNT_W +: CNT_W]) begin
        win_hit[i] = (cnt_q >= rise_act_q[i*CNT_W +: CNT_W]) ||
                     (cnt_q <  fall_act_q[i*CNT_W +: CNT_W]);
      end
    end
  end

  // Next-state logic: counter advance, output update, commit and shadow writes.
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    fs_d       = fs_q;
    pend_d     = pend_q;
    per_act_d  = per_act_q;
    per_sh_d   = per_sh_q;
    rise_act_d = rise_act_q;
    fall_act_d = fall_act_q;
    rise_sh_d  = rise_sh_q;
    fall_sh_d  = fall_sh_q;

    wrap      = run && (cnt_q == (per_act_q - C_ONE));
    wr_valid  = cfg_we && (cfg_addr <= C_MAX_ADDR);
    wr_period = (cfg_wdata[CNT_W-1:0] < C_MIN_PERIOD) ? C_MIN_PERIOD
                                                      : cfg_wdata[CNT_W-1:0];

    if (run) begin
      cnt_d   = wrap ? C_ZERO : (cnt_q + C_ONE);
      phase_d = win_hit;
      fs_d    = (cnt_q == C_ZERO);
    end else begin
      // Frozen: counter and strobes hold, but the start pulse must not stretch.
      fs_d = 1'b0;
    end

    // Commit copies the shadow as it stood before any same-cycle write, so a
    // write landing on the wrap edge stays pending for one more frame.
    if (wrap) begin
      per_act_d  = per_sh_q;
      rise_act_d = rise_sh_q;
      fall_act_d = fall_sh_q;
      pend_d     = 1'b0;
    end

    if (wr_valid) begin
      if (cfg_addr == 5'd0) begin
        per_sh_d = wr_period;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_addr == 5'(i + 1)) begin
          rise_sh_d[i*CNT_W +: CNT_W] = cfg_wdata[2*CNT_W-1:CNT_W];
          fall_sh_d[i*CNT_W +: CNT_W] = cfg_wdata[CNT_W-1:0];
        end
      end
      pend_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset to the default config.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      cnt_q      <= C_ZERO;
      phase_q    <= '0;
      fs_q       <= 1'b0;
      pend_q     <= 1'b0;
      per_act_q  <= C_DEF_PERIOD;
      per_sh_q   <= C_DEF_PERIOD;
      rise_act_q <= DEF_RISE;
      fall_act_q <= DEF_FALL;
      rise_sh_q  <= DEF_RISE;
      fall_sh_q  <= DEF_FALL;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      fs_q       <= fs_d;
      pend_q     <= pend_d;
      per_act_q  <= per_act_d;
      per_sh_q   <= per_sh_d;
      rise_act_q <= rise_act_d;
      fall_act_q <= fall_act_d;
      rise_sh_q  <= rise_sh_d;
      fall_sh_q  <= fall_sh_d;
    end
  end

  assign phase_out   = phase_q;
  assign frame_start = fs_q;
  assign cfg_pending = pend_q;
  assign cnt_out     = cnt_q;

endmodule
`default_nettype wire
